if_prefetch_unit: RTL

//  Instruction-fetch front end that sits directly upstream of the IF/ID register.

---
 rtl/if_prefetch_unit_pkg.sv | 23 ++
 rtl/if_prefetch_unit_fifo.sv | 70 +++++++
 rtl/if_prefetch_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/if_prefetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit and its queue.
package if_prefetch_unit_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_entry_t;

    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_prefetch_unit_fifo.sv
// DEPTH-entry queue of {instr, pc4} pairs; clear wins over push and pop in the same cycle.
module if_prefetch_unit_fifo
    import if_prefetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  fetch_entry_t  i_data,
    input  logic          i_pop,
    input  logic          i_clear,
    output fetch_entry_t  o_head,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    fetch_entry_t  r_last_head;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_CNT);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty & ~i_clear;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Remembers the most recent head so the outputs hold steady while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_head <= '{instr: NOP_WORD, pc4: 32'h0};
        end else if (!o_empty) begin
            r_last_head <= r_mem[r_rd_ptr];
        end
    end

    always_comb begin
        o_head = r_last_head;
        if (!o_empty) o_head = r_mem[r_rd_ptr];
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, talks req/ack to instruction memory,
// and feeds the IF/ID register from a small prefetch queue.
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_addr
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_next;
    logic [31:0]   r_drop_addr;
    logic [31:0]   w_drop_addr_next;
    logic [31:0]   w_redirect_pc;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    fetch_entry_t  w_head;

    assign w_redirect_pc = wordAlign(redirect_addr);
    assign w_pop         = id_valid & id_ready & ~redirect;
    assign w_count_next  = w_count + CW'(w_push) - CW'(w_pop);

    if_prefetch_unit_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_data  ('{instr: imem_rdata, pc4: r_pc + PC_STEP}),
        .i_pop   (w_pop),
        .i_clear (redirect),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_FETCH;
            r_pc        <= wordAlign(RESET_PC);
            r_drop_addr <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_drop_addr <= w_drop_addr_next;
        end
    end

    // A redirect while a request is still outstanding parks in DROP so the stale word is swallowed.
    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_drop_addr_next = r_drop_addr;
        w_push           = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (redirect)     w_pc_next    = w_redirect_pc;
                else if (!w_full) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (redirect) begin
                    w_pc_next = w_redirect_pc;
                    if (imem_ack) begin
                        w_state_next = S_FETCH;
                    end else begin
                        w_drop_addr_next = r_pc;
                        w_state_next     = S_DROP;
                    end
                end else if (imem_ack) begin
                    w_push       = 1'b1;
                    w_pc_next    = r_pc + PC_STEP;
                    w_state_next = (w_count_next < FULL_CNT) ? S_WAIT : S_FETCH;
                end
            end
            S_DROP: begin
                if (redirect) w_pc_next    = w_redirect_pc;
                if (imem_ack) w_state_next = S_FETCH;
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    assign imem_req  = (r_state == S_WAIT) | (r_state == S_DROP);
    assign imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;
    assign id_valid  = ~w_empty;
    assign id_instr  = w_head.instr;
    assign id_pc4    = w_head.pc4;

endmodule
